// File: rtl/noc_local_inject_queue.sv
// Local-port injection queue: frames tile flits, buffers them and feeds the router P input.
// Latency: accepted flit visible on noc_data_out the next cycle; no in->out combinational path.
// Backpressure: in_ready = !full; router stop_out holds the head flit for any number of cycles.
module noc_local_inject_queue #(
  parameter int Width    = 32,
  parameter int Depth    = 4,
  parameter int CntWidth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Width-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [Width-1:0]           noc_data_out,
  output logic                       noc_void_out,
  input  logic                       noc_stop_in,
  output logic [CntWidth-1:0]        pkt_count,
  output logic                       proto_err,
  output logic [$clog2(Depth):0]     level
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q, level_d;
  logic                rdy_en_q;
  state_t              state_q, state_d;
  logic [CntWidth-1:0] pkt_cnt_q;
  logic                err_q;

  logic full, empty, accept, push, drop, pop;
  logic head_bit, tail_bit;

  assign full     = (level_q == LvlW'(Depth));
  assign empty    = (level_q == '0);
  // rdy_en_q keeps in_ready low through reset and for the release cycle
  assign in_ready = rdy_en_q && !full;
  assign accept   = in_valid && in_ready;
  assign head_bit = in_data[Width-1];
  assign tail_bit = in_data[Width-2];
  assign pop      = !empty && !noc_stop_in;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (head_bit) begin
            push    = 1'b1;
            state_d = tail_bit ? IDLE : IN_PKT;
          end else begin
            drop = 1'b1;
          end
        end
        IN_PKT: begin
          if (!head_bit) begin
            push    = 1'b1;
            state_d = tail_bit ? IDLE : IN_PKT;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rdy_en_q  <= 1'b0;
      state_q   <= IDLE;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
      level_q  <= level_d;
      err_q    <= drop;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (mem_q[rd_ptr_q][Width-2]) pkt_cnt_q <= pkt_cnt_q + CntWidth'(1);
      end
    end
  end

  assign noc_void_out = empty;
  assign noc_data_out = empty ? '0 : mem_q[rd_ptr_q];
  assign pkt_count    = pkt_cnt_q;
  assign proto_err    = err_q;
  assign level        = level_q;

endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Randomized bench for noc_local_inject_queue against a queue-based reference model.
module tb_noc_local_inject_queue;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 8;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  noc_data_out;
  logic          noc_void_out;
  logic          noc_stop_in = 1'b0;
  logic [CW-1:0] pkt_count;
  logic          proto_err;
  logic [LW-1:0] level;

  noc_local_inject_queue #(.Width(W), .Depth(D), .CntWidth(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .noc_data_out(noc_data_out), .noc_void_out(noc_void_out), .noc_stop_in(noc_stop_in),
    .pkt_count(pkt_count), .proto_err(proto_err), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: ordered list of flits the router has yet to take
  logic [W-1:0] mq[$];
  bit           m_in_pkt, m_rdy, m_err, m_acc;
  int           m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_pkt = 0; m_rdy = 0; m_err = 0; m_acc = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    check_eq("void", 64'(noc_void_out), 64'(mq.size() == 0));
    check_eq("data", 64'(noc_data_out), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    check_eq("in_ready", 64'(in_ready), 64'(m_rdy && mq.size() < D));
    check_eq("level", 64'(level), 64'(mq.size()));
    check_eq("pkt_count", 64'(pkt_count), 64'(m_cnt));
    check_eq("proto_err", 64'(proto_err), 64'(m_err));
  endtask

  task automatic model_step();
    bit tk, h, t;
    if (!rst) begin
      model_reset();
    end else begin
      m_acc = in_valid && m_rdy && (mq.size() < D);
      tk    = (mq.size() != 0) && !noc_stop_in;
      h     = in_data[W-1];
      t     = in_data[W-2];
      m_err = 0;
      if (tk) begin
        if (mq[0][W-2]) m_cnt = (m_cnt + 1) % (1 << CW);
        void'(mq.pop_front());
      end
      if (m_acc) begin
        if (h != m_in_pkt) begin
          mq.push_back(in_data);
          m_in_pkt = !t;
        end else begin
          m_err = 1;
        end
      end
      m_rdy = 1;
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic s);
    check_outputs();
    in_valid = v; in_data = d; noc_stop_in = s;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int base, sent;
    model_reset();
    @(negedge clk);

    // reset held for 3 cycles, then release
    repeat (3) cycle(1'b0, '0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    check_eq("ready_after_release", 64'(in_ready), 64'd1);

    // single-flit packet
    cycle(1'b1, 32'hC000_00AA, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    check_eq("single_cnt", 64'(pkt_count), 64'd1);

    // 3-flit packet with flit 2 held by stop for 5 cycles
    cycle(1'b1, 32'h8000_0001, 1'b0);
    cycle(1'b1, 32'h0000_0002, 1'b0);
    cycle(1'b1, 32'h4000_0003, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    check_eq("held_flit2", 64'(noc_data_out), 64'h0000_0002);
    repeat (4) cycle(1'b0, '0, 1'b0);
    check_eq("three_cnt", 64'(pkt_count), 64'd2);

    // fill under stop, then drain
    cycle(1'b1, 32'h8000_0011, 1'b1);
    cycle(1'b1, 32'h0000_0012, 1'b1);
    cycle(1'b1, 32'h0000_0013, 1'b1);
    cycle(1'b1, 32'h0000_0014, 1'b1);
    cycle(1'b1, 32'h4000_0015, 1'b1);
    check_eq("full_level", 64'(level), 64'd4);
    check_eq("full_ready", 64'(in_ready), 64'd0);
    repeat (3) cycle(1'b1, 32'h4000_0015, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b0);
    check_eq("fill_cnt", 64'(pkt_count), 64'd3);

    // malformed flits
    cycle(1'b1, 32'h0000_0005, 1'b0);
    check_eq("drop_body_err", 64'(proto_err), 64'd1);
    check_eq("drop_body_level", 64'(level), 64'd0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h8000_0001, 1'b1);
    cycle(1'b1, 32'h8000_0010, 1'b1);
    check_eq("drop_head_err", 64'(proto_err), 64'd1);
    cycle(1'b1, 32'h4000_0002, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0);

    // random flits: framing, drops and stops all random
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) == 0));

    // close any open packet, drain, then wrap the counter with single-flit packets
    cycle(1'b1, 32'h4000_0000, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b0);
    base = m_cnt;
    sent = 0;
    for (int k = 0; k < 5000 && sent < (1 << CW) + 3; k++) begin
      cycle(1'b1, 32'hC000_0000 | W'(sent), ($urandom_range(0, 3) == 0));
      if (m_acc) sent++;
    end
    repeat (8) cycle(1'b0, '0, 1'b0);
    check_eq("wrap_cnt", 64'(pkt_count), 64'((base + (1 << CW) + 3) % (1 << CW)));

    // async reset mid-packet with 3 flits buffered
    cycle(1'b1, 32'h8000_0100, 1'b1);
    cycle(1'b1, 32'h0000_0101, 1'b1);
    cycle(1'b1, 32'h0000_0102, 1'b1);
    check_eq("pre_rst_level", 64'(level), 64'd3);
    rst = 1'b0;
    #1;
    check_eq("arst_void", 64'(noc_void_out), 64'd1);
    check_eq("arst_level", 64'(level), 64'd0);
    check_eq("arst_data", 64'(noc_data_out), 64'd0);
    model_reset();
    @(negedge clk);
    repeat (2) cycle(1'b0, '0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'hC000_0077, 1'b0);
    check_eq("post_rst_data", 64'(noc_data_out), 64'hC000_0077);
    repeat (3) cycle(1'b0, '0, 1'b0);
    check_eq("post_rst_cnt", 64'(pkt_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noc_local_inject_queue.md
Name: noc_local_inject_queue

Overview:
Injection stage between a tile's local-port source and the router's local (P) input. It accepts flits on a valid/ready interface, checks head/tail framing, and buffers flits in a small FIFO. It drives the router's data_p_in and void bit, and honours the router's stop_out bit for the P port with stop-and-hold semantics. It also counts delivered packets for debug.

Parameters:
Width, 32, full flit width including the preamble; preamble is bits [Width-1:Width-2] = {head, tail}.
Depth, 4, number of FIFO entries; power of two, at least 2.
CntWidth, 16, width of the delivered-packet counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_data  in  Width  flit from tile
in_valid  in  1  in_data valid
in_ready  out  1  queue can accept a flit
noc_data_out  out  Width  to router data_p_in
noc_void_out  out  1  to router data_void_in[P]; 1 = no flit
noc_stop_in  in  1  from router stop_out[P]; 1 = flit not taken
pkt_count  out  CntWidth  packets whose tail flit was taken by the router
proto_err  out  1  one-cycle pulse on a dropped malformed flit
level  out  $clog2(Depth)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, level=0, noc_void_out=1, noc_data_out=0, in_ready=0, pkt_count=0, proto_err=0, framing FSM=IDLE. in_ready goes to 1 in the first cycle after rst deasserts. A reset mid-packet discards all buffered flits and any partial packet.
- Input acceptance: a flit is accepted on a rising edge with in_valid=1 and in_ready=1. in_ready = !full. It does not depend on in_valid or noc_stop_in, and there is no full-bypass.
- Framing FSM, evaluated on accepted flits only:
  - IDLE, head=1, tail=1: push; stay IDLE.
  - IDLE, head=1, tail=0: push; go to IN_PKT.
  - IDLE, head=0: drop (no push); pulse proto_err; stay IDLE.
  - IN_PKT, head=0, tail=0: push; stay IN_PKT.
  - IN_PKT, head=0, tail=1: push; go to IDLE.
  - IN_PKT, head=1: drop; pulse proto_err; stay IN_PKT.
  - A dropped flit is still consumed (in_ready was 1).
- Output: noc_void_out = empty. noc_data_out = FIFO head entry when not empty, else all zeros.
- Router transfer: the head flit is taken on a rising edge with noc_void_out=0 and noc_stop_in=0, and is popped on that edge.
  - With noc_stop_in=1, the flit and void are held unchanged into the next cycle, for any number of stop cycles.
  - noc_stop_in is ignored while void=1.
- Latency: a flit accepted at edge k is visible on noc_data_out in the cycle after edge k, with no combinational path from in_data. Minimum input-to-router-take is 1 cycle; sustained throughput is 1 flit/cycle when stop=0.
- Simultaneous push and pop: allowed when not full; level is unchanged. Full with pop: in_ready was already 0 that cycle, so no push. Level updates as +1, -1 or 0 per edge.
- Pointers: log2(Depth)-bit read/write pointers wrap modulo Depth. Full/empty are derived from level.
- pkt_count increments by 1 on each edge where a flit with tail=1 is taken by the router. It wraps from 2^CntWidth-1 to 0.
- proto_err is registered: high for exactly the cycle after the drop edge.

Test Plan:
- Reset then idle: rst low for 3 cycles → void=1, data=0, in_ready=0, pkt_count=0. One cycle after release → in_ready=1.
- Single-flit packet 0xC000_00AA, stop=0 → taken one cycle after acceptance; void back to 1; pkt_count=1; proto_err never high.
- 3-flit packet (0x8000_0001, 0x0000_0002, 0x4000_0003) with stop=1 held for 5 cycles on flit 2 → flit 2 stays stable on noc_data_out for 5 cycles; router sees exactly 3 flits in order; pkt_count=1.
- Fill with stop=1 → after 4 flits, in_ready=0 and level=4. Drop stop → one pop per cycle; in_ready=1 the cycle after the first pop; no flit lost or duplicated.
- Malformed input: body flit 0x0000_0005 while IDLE → dropped, proto_err pulses once, level stays 0. Head 0x8000_0010 sent while IN_PKT → dropped, proto_err pulses.
- Wrap and counter: send 2^16+3 single-flit packets with random stop → pkt_count=3. Pointers wrap with ordering preserved.
- Async reset asserted while level=3 mid-packet → immediately void=1, level=0. After release, a fresh head flit is accepted without error.
